// File: rtl/dpsk_mod.sv
// dpsk_mod -- differential BPSK modulator.
// A bit stream is differentially encoded: each accepted bit XORs into the
// phase state d, one symbol of SPS sample strobes per bit. The carrier is a
// 64-entry sine table driven by a free-running 16-bit phase accumulator and
// is sign-flipped by d. The first DATA symbol is the phase reference.
// Optional build macro: DPSK_PREAMBLE_EN compiles in a PREAMBLE_LEN-symbol
// alternating-phase preamble ahead of the reference symbol.
module dpsk_mod #(
  parameter int                 SPS          = 8,
  parameter int                 PREAMBLE_LEN = 16,
  parameter logic signed [15:0] AMP          = 16'sd16384
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic [15:0]        fcw,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               bit_last,
  output logic               bit_ready,
  output logic signed [15:0] tx_out,
  output logic               tx_valid,
  output logic               busy,
  output logic               underrun
);

  localparam int CW = $clog2(SPS);

  // Reject illegal configurations at elaboration time.
  if (SPS < 2 || SPS > 256 || PREAMBLE_LEN < 1 || PREAMBLE_LEN > 255) begin : g_bad_cfg
    $error("dpsk_mod: SPS must be 2..256 and PREAMBLE_LEN 1..255");
  end

`ifdef DPSK_PREAMBLE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, DATA = 2'd2, LAST = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd2, LAST = 2'd3} state_t;
`endif

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           d, d_n;
  logic           und_n;
  logic [15:0]    ph;
  logic signed [15:0] s;
  logic           sym_tick;
`ifdef DPSK_PREAMBLE_EN
  logic [7:0]     pre_cnt, pre_n;
`endif

  // Quarter-wave sine in Q0.24, scaled by AMP and rounded to nearest at
  // elaboration; the remaining quadrants come from symmetry.
  function automatic logic signed [15:0] sin_lut(input logic [5:0] k);
    logic [4:0]         q;
    longint             t;
    longint             p;
    logic signed [15:0] r;
    q = k[4] ? (5'd16 - {1'b0, k[3:0]}) : {1'b0, k[3:0]};
    case (q)
      5'd0:    t = 64'sd0;
      5'd1:    t = 64'sd1644455;
      5'd2:    t = 64'sd3273072;
      5'd3:    t = 64'sd4870169;
      5'd4:    t = 64'sd6420363;
      5'd5:    t = 64'sd7908725;
      5'd6:    t = 64'sd9320922;
      5'd7:    t = 64'sd10643353;
      5'd8:    t = 64'sd11863283;
      5'd9:    t = 64'sd12968963;
      5'd10:   t = 64'sd13949745;
      5'd11:   t = 64'sd14796184;
      5'd12:   t = 64'sd15500126;
      5'd13:   t = 64'sd16054795;
      5'd14:   t = 64'sd16454846;
      5'd15:   t = 64'sd16696429;
      default: t = 64'sd16777216;
    endcase
    p = (longint'(AMP) * t + 64'sd8388608) >>> 24;
    r = p[15:0];
    return k[5] ? -r : r;
  endfunction

  assign s        = sin_lut(ph[15:10]);
  assign sym_tick = clk_en && (cnt == CW'(SPS - 1));
  assign busy     = (state != IDLE);

  // Next-state, symbol counter, phase state and ready strobe.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    d_n       = d;
    und_n     = underrun;
    bit_ready = 1'b0;
`ifdef DPSK_PREAMBLE_EN
    pre_n     = pre_cnt;
`endif
    if (clk_en && state != IDLE)
      cnt_n = sym_tick ? '0 : cnt + 1'b1;
    case (state)
      IDLE: begin
        // Frame start: the pending bit stays on the bus until the first tick.
        if (bit_valid) begin
          cnt_n = '0;
          d_n   = 1'b0;
`ifdef DPSK_PREAMBLE_EN
          pre_n   = '0;
          state_n = PRE;
`else
          state_n = DATA;
`endif
        end
      end
`ifdef DPSK_PREAMBLE_EN
      PRE: begin
        if (sym_tick) begin
          d_n = ~d;
          if (pre_cnt == 8'(PREAMBLE_LEN - 1))
            state_n = DATA;
          else
            pre_n = pre_cnt + 8'd1;
        end
      end
`endif
      DATA: begin
        // A reset cycle never counts as a handshake.
        bit_ready = sym_tick && rst;
        if (sym_tick) begin
          if (bit_valid) begin
            d_n = d ^ bit_in;
            if (bit_last)
              state_n = LAST;
          end else begin
            und_n = 1'b1;
          end
        end
      end
      LAST: begin
        if (sym_tick)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      d        <= 1'b0;
      underrun <= 1'b0;
`ifdef DPSK_PREAMBLE_EN
      pre_cnt  <= '0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      d        <= d_n;
      underrun <= und_n;
`ifdef DPSK_PREAMBLE_EN
      pre_cnt  <= pre_n;
`endif
    end
  end

  // Carrier phase accumulator; runs on every strobe, including IDLE.
  always_ff @(posedge sys_clk) begin
    if (!rst)
      ph <= '0;
    else if (clk_en)
      ph <= ph + fcw;
  end

  // Output sample register: silent in IDLE, carrier sign set by d.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      tx_out   <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= clk_en;
      if (clk_en) begin
        if (state == IDLE)
          tx_out <= '0;
        else
          tx_out <= d ? -s : s;
      end
    end
  end

endmodule

// File: doc/dpsk_mod.md
DPSK_MOD -- requirements
Module: dpsk_mod

Interface
REQ-001 The module SHALL have parameter SPS, default 8, giving sample strobes (clk_en pulses) per symbol, legal range 2..256.
REQ-002 The module SHALL have parameter PREAMBLE_LEN, default 16, giving preamble symbols per frame, legal range 1..255.
REQ-003 The module SHALL have parameter AMP, default 16'sd16384, giving the carrier peak amplitude.
REQ-004 sys_clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 clk_en  input  1  sample strobe; one output sample per pulse.
REQ-007 fcw  input  16  carrier frequency control word; sampled on every clk_en.
REQ-008 bit_in  input  1  data bit.
REQ-009 bit_valid  input  1  bit_in/bit_last valid.
REQ-010 bit_last  input  1  marks the final bit of a frame.
REQ-011 bit_ready  output  1  bit accepted this cycle when bit_valid is also 1.
REQ-012 tx_out  output  signed 16  modulated carrier sample.
REQ-013 tx_valid  output  1  tx_out updated this cycle.
REQ-014 busy  output  1  frame in progress (state not IDLE).
REQ-015 underrun  output  1  sticky; no valid bit at a DATA symbol boundary.

Function
REQ-016 The FSM SHALL have states IDLE, PRE, DATA and LAST.
REQ-017 The symbol counter cnt SHALL advance 0..SPS-1 on each clk_en outside IDLE and wrap to 0; sym_tick SHALL be defined as clk_en AND cnt==SPS-1.
REQ-018 In IDLE, bit_valid=1 SHALL load cnt=0 and d=0 and move to PRE (macro defined) or DATA (macro undefined); the bit SHALL NOT be consumed.
REQ-019 In PRE, each sym_tick SHALL toggle d; after PREAMBLE_LEN sym_ticks the FSM SHALL enter DATA with d held.
REQ-020 In DATA, bit_ready SHALL equal sym_tick combinationally; it SHALL be 0 in all other states.
REQ-021 A handshake (bit_valid AND bit_ready) SHALL set d <= d XOR bit_in; with bit_last=1 the FSM SHALL move to LAST.
REQ-022 A DATA sym_tick with bit_valid=0 SHALL leave d unchanged, set underrun, and remain in DATA.
REQ-023 In LAST, the next sym_tick SHALL return the FSM to IDLE.
REQ-024 The first DATA symbol SHALL be the phase reference, transmitted with the d value held at DATA entry.
REQ-025 The phase accumulator ph (16 bit) SHALL add fcw on each clk_en, wrapping modulo 2^16; it SHALL keep running in IDLE.
REQ-026 s SHALL be a 64-entry table of round(AMP*sin(2*pi*k/64)) indexed by ph[15:10].
REQ-027 On clk_en, tx_out SHALL be registered to 0 in IDLE, to s when d=0, and to -s when d=1; latency SHALL be 1 cycle.
REQ-028 tx_valid SHALL be clk_en delayed by one cycle.
REQ-029 Outside clk_en cycles, tx_out SHALL hold its value.
REQ-030 bit_valid deasserted before a handshake SHALL be legal and SHALL NOT cause an error other than REQ-022.

Reset
REQ-031 rst=0 at a rising edge SHALL set state=IDLE, cnt=0, d=0, ph=0, tx_out=0, tx_valid=0 and underrun=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame; no handshake SHALL occur in the reset cycle.
REQ-033 underrun SHALL clear only on reset.

Configuration
REQ-034 Macro DPSK_PREAMBLE_EN defined: the PRE state and the PREAMBLE_LEN toggling preamble SHALL be compiled in.
REQ-035 Macro DPSK_PREAMBLE_EN undefined: PRE logic SHALL be absent; IDLE SHALL go directly to DATA; parameter PREAMBLE_LEN SHALL be ignored.

Verification (SPS=4, fcw=16'h1000, AMP=16384, clk_en=1 every cycle)
REQ-036 Reset, then idle for 10 cycles -> tx_out=0, busy=0, bit_ready=0, underrun=0.
REQ-037 Macro undefined; frame of bits 1,0,1 with bit_last on the third bit -> d sequence 0,1,1,0 (one symbol each); exactly 3 bit_ready pulses, 4 cycles apart; IDLE after 16 clk_en.
REQ-038 Macro defined, PREAMBLE_LEN=4 -> 4 symbols with sign alternating +,-,+,-, then data starting at d=0; first bit_ready 20 clk_en after start.
REQ-039 tx_out with d=0 and fcw=16'h1000 -> samples repeat 0,6270,11585,15137,16384,... period 16; with d=1 the samples are exact negations.
REQ-040 bit_valid held 0 across one DATA sym_tick -> underrun=1, d unchanged; frame continues at the next tick.
REQ-041 rst=0 asserted during DATA -> next cycle busy=0, tx_out=0, ph=0; a new frame then starts cleanly.
